// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: operand-forwarding select and hazard-stall generator.
// Tracks the EX/MEM/WB producers in a shadow scoreboard. It drives the
// EX-stage operand mux selects and a combinational stall for the front end.
// Build option: FORWARDING_EN
//   defined   - forwarding from EX/MEM; stall only on load-use.
//   undefined - no forwarding (selects stay 0); stall until the producer
//               has left WB.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   id_valid        - ID stage holds a real instruction
//   id_src1/id_src2 - ID source registers
//   id_dest         - ID destination register
//   id_wb_en        - ID instruction writes id_dest
//   id_is_load      - ID instruction is a load
//   flush           - squash the ID instruction this cycle
//   sel_src1/2      - registered EX mux selects (0 regfile, 1 MEM, 2 WB)
//   stall           - combinational hold for PC and IF/ID
//   stall_cnt       - saturating count of stall cycles
module fwd_sel_gen #(
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            sel_src1,
  output logic [1:0]            sel_src2,
  output logic                  stall,
  output logic [15:0]           stall_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic                  is_load;
  } sb_entry_t;

  // Source match against one entry, split as {load producer, non-load producer}.
  function automatic logic [1:0] match(input sb_entry_t e,
                                       input logic [REG_ADDR_W-1:0] src);
    logic m;
    m = e.valid && e.wb_en && (e.dest == src) && (src != '0);
    return {m && e.is_load, m && !e.is_load};
  endfunction

`ifdef FORWARDING_EN
  // Newer producer wins: a non-load in EX beats anything in MEM.
  function automatic logic [1:0] fwd_sel(input logic [1:0] m_ex,
                                         input logic [1:0] m_mem);
    if (m_ex[0])      return 2'd1;
    else if (|m_mem)  return 2'd2;
    else              return 2'd0;
  endfunction
`endif

  sb_entry_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_entry;
  logic [1:0]            sel1_q, sel1_d, sel2_q, sel2_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb;

  // Hazard detection, next scoreboard, selects and counter.
  always_comb begin
    ex_d     = '0;
    mem_d    = ex_q;
    wb_d     = mem_q;
    sel1_d   = 2'd0;
    sel2_d   = 2'd0;
    cnt_d    = cnt_q;
    id_entry = '{valid: id_valid, dest: id_dest, wb_en: id_wb_en,
                 is_load: id_is_load};

    m1_ex  = match(ex_q,  id_src1);
    m1_mem = match(mem_q, id_src1);
    m1_wb  = match(wb_q,  id_src1);
    m2_ex  = match(ex_q,  id_src2);
    m2_mem = match(mem_q, id_src2);
    m2_wb  = match(wb_q,  id_src2);

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    stall = id_valid && !flush && (m1_ex[1] || m2_ex[1]);
    if (!stall && !flush) begin
      sel1_d = fwd_sel(m1_ex, m1_mem);
      sel2_d = fwd_sel(m2_ex, m2_mem);
    end
`else
    stall = id_valid && !flush &&
            (|{m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb});
`endif

    // EX receives a bubble whenever the ID instruction does not advance.
    if (id_valid && !stall && !flush) ex_d = id_entry;

    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Scoreboard, select and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      sel1_q <= 2'd0;
      sel2_q <= 2'd0;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sel_src1  = sel1_q;
  assign sel_src2  = sel2_q;
  assign stall_cnt = cnt_q;

endmodule
